// File: rtl/tick_scheduler.sv
// tick_scheduler: divide-by-(N+1) tick and phase generator with run/stop/step control
// and a handshaked divide ratio that only changes at period boundaries.
module tick_scheduler #(
  parameter int WIDTH       = 9,
  parameter int DEFAULT_DIV = 511
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cfg_div,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  output logic             tick,
  output logic             phase,
  output logic             running,
  output logic [WIDTH-1:0] count
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STEP} state_t;
  state_t           r_state, w_state_n;
  logic [WIDTH-1:0] r_div, r_pend, r_count;
  logic [WIDTH-1:0] w_div_n, w_pend_n, w_count_n, w_apply;
  logic             r_pend_v, r_tick, r_phase, r_running;
  logic             w_pend_v_n, w_tick_n, w_phase_n;
  logic             w_busy, w_wrap, w_hs;
  assign w_busy    = r_state != S_IDLE;
  assign w_wrap    = w_busy && r_count == r_div;
  assign w_hs      = cfg_valid && cfg_ready;
  // Ratio taken at a boundary: a same-edge handshake, else whatever is pending.
  assign w_apply   = w_hs ? cfg_div : r_pend_v ? r_pend : r_div;
  assign cfg_ready = ~r_pend_v;
  assign tick      = r_tick;
  assign phase     = r_phase;
  assign running   = r_running;
  assign count     = r_count;
  always_comb begin
    w_state_n  = r_state;
    w_div_n    = r_div;
    w_pend_n   = r_pend;
    w_pend_v_n = r_pend_v;
    w_count_n  = '0;
    w_tick_n   = 1'b0;
    w_phase_n  = r_phase;
    if (!w_busy) begin
      if (w_hs) w_div_n = cfg_div;
      w_state_n = start ? S_RUN : step ? S_STEP : S_IDLE;
    end else if (stop) begin
      w_state_n  = S_IDLE;
      w_div_n    = w_apply;
      w_pend_v_n = 1'b0;
    end else if (w_wrap) begin
      w_tick_n   = 1'b1;
      w_phase_n  = ~r_phase;
      w_div_n    = w_apply;
      w_pend_v_n = 1'b0;
      w_state_n  = (r_state == S_STEP && !start) ? S_IDLE : S_RUN;
    end else begin
      w_count_n = r_count + 1'b1;
      if (w_hs) begin
        w_pend_n   = cfg_div;
        w_pend_v_n = 1'b1;
      end
      if (start) w_state_n = S_RUN;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_div     <= WIDTH'(DEFAULT_DIV);
      r_pend    <= '0;
      r_pend_v  <= 1'b0;
      r_count   <= '0;
      r_tick    <= 1'b0;
      r_phase   <= 1'b0;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_div     <= w_div_n;
      r_pend    <= w_pend_n;
      r_pend_v  <= w_pend_v_n;
      r_count   <= w_count_n;
      r_tick    <= w_tick_n;
      r_phase   <= w_phase_n;
      r_running <= w_state_n != S_IDLE;
    end
  end
endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: scenario tasks compared against arithmetic expectations
// (k edges after start: count = k mod (N+1), ticks so far = k div (N+1)).
module tb_tick_scheduler;
  logic       clk = 0, reset = 0, cfg_valid = 0, start = 0, stop = 0, step = 0;
  logic [8:0] cfg_div = 0;
  logic       cfg_ready, tick, phase, running;
  logic [8:0] count;
  int         errors = 0, checks = 0;

  tick_scheduler #(.WIDTH(9), .DEFAULT_DIV(511)) dut (
    .clk(clk), .reset(reset), .cfg_div(cfg_div), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .start(start), .stop(stop), .step(step),
    .tick(tick), .phase(phase), .running(running), .count(count)
  );

  always #5 clk = ~clk;

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 0; stop = 0; step = 0; cfg_valid = 0;
    adv();
    reset = 1;
    #3;
    reset = 0;
    adv();
  endtask

  task automatic load_div(input int n);
    cfg_div = 9'(n);
    cfg_valid = 1;
    adv();
    cfg_valid = 0;
  endtask

  task automatic kick(input bit use_step);
    if (use_step) step = 1; else start = 1;
    adv();
    start = 0;
    step = 0;
  endtask

  task automatic test_reset();
    logic [12:0] got, exp;
    do_reset();
    got = {running, tick, phase, count, cfg_ready};
    exp = {1'b0, 1'b0, 1'b0, 9'd0, 1'b1};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_default();
    logic [11:0] got, exp;
    do_reset();
    kick(0);
    for (int k = 0; k <= 1100; k++) begin
      if (k > 0) adv();
      got = {running, tick, phase, count};
      exp = {1'b1, 1'(k > 0 && k % 512 == 0), 1'((k / 512) & 1), 9'(k % 512)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL default_period k=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_random_div();
    logic [11:0] got, exp;
    bit          p0;
    int          n, kk;
    do_reset();
    p0 = 0;
    repeat (6) begin
      n  = $urandom_range(0, 20);
      kk = $urandom_range(2 * (n + 1), 4 * (n + 1) + 5);
      load_div(n);
      kick(0);
      for (int k = 0; k <= kk; k++) begin
        if (k > 0) begin
          start = ($urandom % 3) == 0;
          step  = ($urandom % 3) == 0;
          adv();
        end
        got = {running, tick, phase, count};
        exp = {1'b1, 1'(k > 0 && k % (n + 1) == 0), 1'(p0 ^ ((k / (n + 1)) & 1)), 9'(k % (n + 1))};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL random_run n=%0d k=%0d got=%h exp=%h", n, k, got, exp);
        end
      end
      start = 0; step = 0; stop = 1;
      adv();
      stop = 0;
      p0 = p0 ^ 1'((kk / (n + 1)) & 1);
      got = {running, tick, phase, count};
      exp = {1'b0, 1'b0, p0, 9'd0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_stop n=%0d got=%h exp=%h", n, got, exp);
      end
    end
  endtask

  task automatic test_reconfig();
    logic [11:0] got, exp;
    int          c, newn, per, ticks;
    for (int pass = 0; pass < 2; pass++) begin
      c    = pass == 0 ? $urandom_range(0, 2) : 3;
      newn = $urandom_range(5, 15);
      do_reset();
      load_div(3);
      kick(0);
      cfg_div = 9'(newn);
      for (int k = 0; k <= 4 + 3 * (newn + 1); k++) begin
        per   = k <= 4 ? k % 4 : (k - 4) % (newn + 1);
        ticks = k < 4 ? 0 : 1 + (k - 4) / (newn + 1);
        got = {cfg_ready, tick, phase, count};
        exp = {1'(!(k > c && k < 4)), 1'(k >= 4 && per == 0), 1'(ticks & 1), 9'(per)};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL reconfig c=%0d new=%0d k=%0d got=%h exp=%h", c, newn, k, got, exp);
        end
        cfg_valid = k == c;
        adv();
      end
      cfg_valid = 0;
      stop = 1;
      adv();
      stop = 0;
    end
  endtask

  task automatic test_div0();
    logic [11:0] got, exp;
    do_reset();
    load_div(0);
    kick(0);
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) adv();
      got = {running, tick, phase, count};
      exp = {1'b1, 1'(k > 0), 1'(k & 1), 9'd0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL div0_run k=%0d got=%h exp=%h", k, got, exp);
      end
    end
    stop = 1;
    adv();
    stop = 0;
    got = {running, tick, phase, count};
    exp = {1'b0, 1'b0, 1'b0, 9'd0};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL div0_stop got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_step();
    logic [11:0] got, exp;
    do_reset();
    load_div(4);
    kick(1);
    for (int k = 0; k <= 25; k++) begin
      if (k > 0) adv();
      got = {running, tick, phase, count};
      exp = {1'(k < 5), 1'(k == 5), 1'(k >= 5), 9'(k < 5 ? k : 0)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single_step k=%0d got=%h exp=%h", k, got, exp);
      end
    end
  endtask

  task automatic test_stop_wrap();
    logic [11:0] got, exp;
    do_reset();
    load_div(3);
    kick(0);
    repeat (3) adv();
    stop = 1;
    adv();
    stop = 0;
    for (int k = 0; k < 3; k++) begin
      got = {running, tick, phase, count};
      exp = {1'b0, 1'b0, 1'b0, 9'd0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL stop_on_wrap cyc=%0d got=%h exp=%h", k, got, exp);
      end
      adv();
    end
  endtask

  task automatic test_async_reset();
    logic [12:0] got, exp;
    do_reset();
    load_div(7);
    kick(0);
    repeat (13) adv();
    got = {running, tick, phase, count, cfg_ready};
    exp = {1'b1, 1'b0, 1'b1, 9'd5, 1'b1};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL async_pre got=%h exp=%h", got, exp);
    end
    #2;
    reset = 1;
    #1;
    got = {running, tick, phase, count, cfg_ready};
    exp = {1'b0, 1'b0, 1'b0, 9'd0, 1'b1};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL async_during got=%h exp=%h", got, exp);
    end
    #2;
    reset = 0;
    repeat (2) adv();
    got = {running, tick, phase, count, cfg_ready};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL async_after got=%h exp=%h", got, exp);
    end
  endtask

  initial begin
    test_reset();
    test_default();
    test_random_div();
    test_reconfig();
    test_div0();
    test_step();
    test_stop_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end
endmodule
